// File: rtl/alg_amba_apbsplit.sv
// APB 1:N address splitter: routes one upstream APB master to NUM_SLAVES targets by upper address bits.
// Optional feature macro ALG_AMBA_APBSPLIT_TIMEOUT_EN aborts ACCESS phases that exceed TIMEOUT_CYCLES.
module alg_amba_apbsplit #(
    parameter int          ADDR_WIDTH     = 22,
    parameter int          NUM_SLAVES     = 4,
    parameter int          SLV_ADDR_BITS  = 18,
    parameter int          TIMEOUT_CYCLES = 64,
    parameter logic [31:0] DEFAULT_RDATA  = 32'hDEAD_BEEF
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [ADDR_WIDTH-1:0]    s_addr,
    input  logic                     s_sel,
    input  logic                     s_enable,
    input  logic                     s_write,
    input  logic [31:0]              s_wdata,
    output logic [31:0]              s_rdata,
    output logic                     s_ready,
    output logic [ADDR_WIDTH-1:0]    m_addr,
    output logic                     m_write,
    output logic [31:0]              m_wdata,
    output logic                     m_enable,
    output logic [NUM_SLAVES-1:0]    m_sel,
    input  logic [NUM_SLAVES*32-1:0] m_rdata,
    input  logic [NUM_SLAVES-1:0]    m_ready,
    output logic                     err_pulse,
    output logic [7:0]               err_count
);

    localparam int IDX_W = ADDR_WIDTH - SLV_ADDR_BITS;

    if (NUM_SLAVES < 1 || NUM_SLAVES > 16 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
        $error("alg_amba_apbsplit: NUM_SLAVES must be 1..16 and TIMEOUT_CYCLES >= 2");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_ERR,
        ST_END
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    write_q, write_d;
    logic [31:0]             wdata_q, wdata_d;
    logic                    enable_q, enable_d;
    logic [NUM_SLAVES-1:0]   sel_q, sel_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    ready_q, ready_d;
    logic                    err_pulse_q, err_pulse_d;
    logic [7:0]              err_count_q, err_count_d;
    logic [IDX_W-1:0]        idx_q, idx_d;

    logic [IDX_W-1:0]        s_idx;
    logic                    s_mapped;
    logic [31:0]             tgt_rdata;
    logic                    tgt_ready;
    logic [7:0]              err_count_inc;

`ifdef ALG_AMBA_APBSPLIT_TIMEOUT_EN
    localparam int TMO_W = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;
    logic [TMO_W-1:0]        tmo_q, tmo_d;
`endif

    assign s_idx         = s_addr[ADDR_WIDTH-1:SLV_ADDR_BITS];
    assign s_mapped      = int'(s_idx) < NUM_SLAVES;
    assign err_count_inc = (err_count_q == 8'hFF) ? err_count_q : err_count_q + 8'd1;

    // Only the latched target's ready/rdata lane matters; every other lane is ignored.
    always_comb begin
        tgt_rdata = '0;
        tgt_ready = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                tgt_rdata = m_rdata[32*i +: 32];
                tgt_ready = m_ready[i];
            end
        end
    end

    // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        write_d     = write_q;
        wdata_d     = wdata_q;
        enable_d    = enable_q;
        sel_d       = sel_q;
        rdata_d     = rdata_q;
        ready_d     = 1'b0;
        err_pulse_d = 1'b0;
        err_count_d = err_count_q;
        idx_d       = idx_q;
`ifdef ALG_AMBA_APBSPLIT_TIMEOUT_EN
        tmo_d       = tmo_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (s_sel) begin
                    addr_d  = s_addr;
                    write_d = s_write;
                    wdata_d = s_wdata;
                    idx_d   = s_idx;
                    if (s_mapped) begin
                        for (int i = 0; i < NUM_SLAVES; i++) begin
                            sel_d[i] = (s_idx == IDX_W'(i));
                        end
                        state_d = ST_SETUP;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_SETUP: begin
                if (s_enable) begin
                    enable_d = 1'b1;
`ifdef ALG_AMBA_APBSPLIT_TIMEOUT_EN
                    tmo_d    = '0;
`endif
                    state_d  = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (tgt_ready) begin
                    sel_d    = '0;
                    enable_d = 1'b0;
                    ready_d  = 1'b1;
                    if (!write_q) rdata_d = tgt_rdata;
                    state_d  = ST_END;
                end
`ifdef ALG_AMBA_APBSPLIT_TIMEOUT_EN
                else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    sel_d       = '0;
                    enable_d    = 1'b0;
                    ready_d     = 1'b1;
                    err_pulse_d = 1'b1;
                    err_count_d = err_count_inc;
                    if (!write_q) rdata_d = DEFAULT_RDATA;
                    state_d     = ST_END;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            ST_ERR: begin
                if (s_enable) begin
                    ready_d     = 1'b1;
                    err_pulse_d = 1'b1;
                    err_count_d = err_count_inc;
                    if (!write_q) rdata_d = DEFAULT_RDATA;
                    state_d     = ST_END;
                end
            end
            // One dead cycle so a still-high s_sel from the finished transfer is not re-accepted.
            ST_END: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            write_q     <= 1'b0;
            wdata_q     <= '0;
            enable_q    <= 1'b0;
            sel_q       <= '0;
            rdata_q     <= '0;
            ready_q     <= 1'b0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
            idx_q       <= '0;
`ifdef ALG_AMBA_APBSPLIT_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            write_q     <= write_d;
            wdata_q     <= wdata_d;
            enable_q    <= enable_d;
            sel_q       <= sel_d;
            rdata_q     <= rdata_d;
            ready_q     <= ready_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
            idx_q       <= idx_d;
`ifdef ALG_AMBA_APBSPLIT_TIMEOUT_EN
            tmo_q       <= tmo_d;
`endif
        end
    end

    assign s_rdata   = rdata_q;
    assign s_ready   = ready_q;
    assign m_addr    = addr_q;
    assign m_write   = write_q;
    assign m_wdata   = wdata_q;
    assign m_enable  = enable_q;
    assign m_sel     = sel_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_alg_amba_apbsplit.sv
// Self-checking bench for alg_amba_apbsplit: directed plan cases plus randomized transfers
// checked against a transaction-level model of decode, latency, read data and error counting.
module tb_alg_amba_apbsplit;

    localparam int          AW  = 22;
    localparam int          NS  = 4;
    localparam int          SAB = 18;
    localparam int          TMO = 8;
    localparam logic [31:0] DEF = 32'hDEAD_BEEF;
    localparam int          NEVER = 1000;

    logic              clk = 1'b0;
    logic              rstn;
    logic [AW-1:0]     s_addr;
    logic              s_sel, s_enable, s_write;
    logic [31:0]       s_wdata, s_rdata;
    logic              s_ready;
    logic [AW-1:0]     m_addr;
    logic              m_write, m_enable;
    logic [31:0]       m_wdata;
    logic [NS-1:0]     m_sel;
    logic [NS*32-1:0]  m_rdata;
    logic [NS-1:0]     m_ready;
    logic              err_pulse;
    logic [7:0]        err_count;

    alg_amba_apbsplit #(
        .ADDR_WIDTH(AW), .NUM_SLAVES(NS), .SLV_ADDR_BITS(SAB),
        .TIMEOUT_CYCLES(TMO), .DEFAULT_RDATA(DEF)
    ) dut (
        .clk(clk), .rstn(rstn),
        .s_addr(s_addr), .s_sel(s_sel), .s_enable(s_enable), .s_write(s_write),
        .s_wdata(s_wdata), .s_rdata(s_rdata), .s_ready(s_ready),
        .m_addr(m_addr), .m_write(m_write), .m_wdata(m_wdata), .m_enable(m_enable),
        .m_sel(m_sel), .m_rdata(m_rdata), .m_ready(m_ready),
        .err_pulse(err_pulse), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: last read word seen upstream, error count, completed transfers.
    logic [31:0] exp_rdata;
    int          exp_err;
    int          exp_ready;

    int ready_seen = 0;
    int onehot_bad = 0;
    int enable_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (s_ready === 1'b1) ready_seen++;
        if ($countones(m_sel) > 1) onehot_bad++;
        if (m_enable === 1'b1 && m_sel == '0) enable_bad++;
    end

    // One complete upstream transfer; the selected target raises ready after 'waits' enabled cycles.
    task automatic do_xfer(input logic [AW-1:0] addr, input logic wr, input logic [31:0] wd,
                           input logic [31:0] lane_data, input int waits, input bit hold_sel);
        int            idx;
        bit            mapped, timed_out, err, done, sel_ok;
        int            cyc, en_cycles, acc_cycles;
        logic [NS-1:0] exp_sel;
        logic [31:0]   lane;

        idx       = int'(addr[AW-1:SAB]);
        mapped    = idx < NS;
        timed_out = 1'b0;
`ifdef ALG_AMBA_APBSPLIT_TIMEOUT_EN
        timed_out = mapped && (waits >= TMO);
`endif
        err        = !mapped || timed_out;
        acc_cycles = timed_out ? TMO : waits + 1;
        exp_sel    = '0;
        if (mapped) exp_sel[idx] = 1'b1;

        m_rdata = {$urandom, $urandom, $urandom, $urandom};
        lane    = '0;
        if (mapped) begin
            m_rdata[32*idx +: 32] = lane_data;
            lane = lane_data;
        end

        s_addr   = addr;
        s_write  = wr;
        s_wdata  = wd;
        s_sel    = 1'b1;
        s_enable = 1'b0;
        m_ready  = NS'($urandom) & ~exp_sel;
        @(negedge clk);
        cyc = 1;
        check("setup_sel", 64'(m_sel), 64'(exp_sel));
        check("setup_addr", 64'(m_addr), 64'(addr));
        check("setup_write", 64'(m_write), 64'(wr));
        check("setup_wdata", 64'(m_wdata), 64'(wd));
        check("setup_enable", 64'(m_enable), 64'(0));

        s_enable  = 1'b1;
        done      = 1'b0;
        sel_ok    = 1'b1;
        en_cycles = 0;
        while (!done && cyc < 200) begin
            m_ready = NS'($urandom) & ~exp_sel;
            if (mapped && m_enable === 1'b1) begin
                m_ready[idx] = (en_cycles >= waits);
                en_cycles++;
            end
            @(negedge clk);
            cyc++;
            if (s_ready === 1'b1) done = 1'b1;
            else if (m_sel !== exp_sel) sel_ok = 1'b0;
        end

        if (!wr) exp_rdata = err ? DEF : lane;
        if (err && exp_err < 255) exp_err++;
        exp_ready++;

        check("completed", 64'(done), 64'(1));
        check("sel_held", 64'(sel_ok), 64'(1));
        check("latency", 64'(cyc), 64'(mapped ? 2 + acc_cycles : 2));
        check("enable_cycles", 64'(en_cycles), 64'(mapped ? acc_cycles : 0));
        check("rdata", 64'(s_rdata), 64'(exp_rdata));
        check("err_pulse", 64'(err_pulse), 64'(err));
        check("err_count", 64'(err_count), 64'(exp_err));
        check("done_sel", 64'(m_sel), 64'(0));
        check("done_enable", 64'(m_enable), 64'(0));

        s_enable = 1'b0;
        m_ready  = '0;
        if (!hold_sel) s_sel = 1'b0;
        @(negedge clk);
        check("ready_pulse_end", 64'(s_ready), 64'(0));
        check("err_pulse_end", 64'(err_pulse), 64'(0));
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rstn     = 1'b0;
        s_addr   = '0;
        s_sel    = 1'b0;
        s_enable = 1'b0;
        s_write  = 1'b0;
        s_wdata  = '0;
        m_rdata  = '0;
        m_ready  = '0;
        exp_rdata = '0;
        exp_err   = 0;
        exp_ready = 0;
        repeat (2) @(negedge clk);
        check("rst_sel", 64'(m_sel), 64'(0));
        check("rst_enable", 64'(m_enable), 64'(0));
        check("rst_ready", 64'(s_ready), 64'(0));
        check("rst_rdata", 64'(s_rdata), 64'(0));
        check("rst_err_pulse", 64'(err_pulse), 64'(0));
        check("rst_err_count", 64'(err_count), 64'(0));
        check("rst_addr", 64'(m_addr), 64'(0));
        rstn = 1'b1;
        @(negedge clk);

        // Directed plan cases.
        do_xfer(22'h08_0010, 1'b0, 32'h0, 32'hA5A5_0001, 0, 1'b0);
        do_xfer(22'h00_0124, 1'b1, 32'h1234_5678, 32'h0BAD_0BAD, 3, 1'b0);
        do_xfer(22'h3F_0000, 1'b0, 32'h0, 32'h0, 0, 1'b0);
        do_xfer(22'h08_0020, 1'b0, 32'h0, 32'h2222_0002, 1, 1'b1);
        do_xfer(22'h04_0040, 1'b0, 32'h0, 32'h1111_0001, 0, 1'b0);
        check("ready_pulses_hold", 64'(ready_seen), 64'(exp_ready));

        // Asynchronous reset in the middle of an ACCESS phase.
        s_addr   = 22'h0C_0004;
        s_write  = 1'b0;
        s_sel    = 1'b1;
        s_enable = 1'b0;
        m_ready  = '0;
        @(negedge clk);
        s_enable = 1'b1;
        repeat (3) @(negedge clk);
        check("pre_rst_enable", 64'(m_enable), 64'(1));
        rstn = 1'b0;
        #1;
        check("midrst_sel", 64'(m_sel), 64'(0));
        check("midrst_enable", 64'(m_enable), 64'(0));
        check("midrst_ready", 64'(s_ready), 64'(0));
        check("midrst_err_count", 64'(err_count), 64'(0));
        check("midrst_rdata", 64'(s_rdata), 64'(0));
        s_sel    = 1'b0;
        s_enable = 1'b0;
        exp_rdata = '0;
        exp_err   = 0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        do_xfer(22'h0C_0008, 1'b0, 32'h0, 32'hC0DE_0003, 2, 1'b0);

`ifdef ALG_AMBA_APBSPLIT_TIMEOUT_EN
        // Hung target aborts after TMO ACCESS cycles; ready in the last cycle still completes normally.
        do_xfer(22'h0C_0010, 1'b0, 32'h0, 32'h3333_3333, NEVER, 1'b0);
        do_xfer(22'h0C_0014, 1'b0, 32'h0, 32'h4444_4444, TMO - 1, 1'b0);
        do_xfer(22'h0C_0018, 1'b1, 32'h5555_5555, 32'h0, NEVER, 1'b0);
`endif

        // Randomized mix of mapped and unmapped reads/writes with varied wait states.
        for (int n = 0; n < 60; n++) begin
            logic [AW-1:0] a;
            a = AW'($urandom);
            if ($urandom_range(0, 1) == 1) a[AW-1:AW-2] = 2'b00;
            do_xfer(a, 1'($urandom), $urandom, $urandom, $urandom_range(0, 4), 1'($urandom_range(0, 3) == 0));
        end
        s_sel = 1'b0;
        @(negedge clk);

        // Drive the error counter past its ceiling.
        for (int n = 0; n < 260; n++) begin
            logic [AW-1:0] a;
            a = AW'($urandom);
            a[AW-1:SAB] = 4'($urandom_range(NS, 15));
            do_xfer(a, 1'($urandom), $urandom, $urandom, 0, 1'b0);
        end
        check("err_count_sat", 64'(err_count), 64'(255));

        check("ready_pulses_total", 64'(ready_seen), 64'(exp_ready));
        check("sel_onehot", 64'(onehot_bad), 64'(0));
        check("enable_has_sel", 64'(enable_bad), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
